// File: rtl/dm_sized.sv
// Sized data memory for the MEM stage: byte/half/word access,
// wait-state timing, lane masking and error flagging.
module dm_sized #(
  parameter int DEPTH      = 128,
  parameter int AW         = 9,
  parameter int WAIT       = 0,
  parameter int BIG_ENDIAN = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic          rd,
  input  logic          wr,
  input  logic [1:0]    size,
  input  logic          uns,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          stall,
  output logic          err
);

  localparam int MW = $clog2(DEPTH);
  localparam logic [3:0] WL = 4'(WAIT);

  logic [31:0]   mem [DEPTH];
  logic [3:0]    cnt;
  logic [AW+3:0] held;
  logic [AW+3:0] cur;
  logic          req;
  logic          bad;
  logic          chg;
  logic          cnt_en;
  logic          fin;
  logic          we;
  logic          hsel;
  logic [1:0]    lane;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [31:0]   word;
  logic [31:0]   ext;
  logic [7:0]    b;
  logic [15:0]   h;
  logic [MW-1:0] idx;

  assign cur = {addr, size, rd, wr};
  assign idx = addr[MW+1:2];
  assign req = (rd | wr) & ~rst;

  always_comb begin
    bad = 1'b0;
    unique case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr[0];
      2'b10:   bad = |addr[1:0];
      default: bad = 1'b1;
    endcase
    if (32'(addr[AW-1:2]) >= 32'(DEPTH))
      bad = 1'b1;
  end

  // Any change of the held request mid-access restarts the count
  assign chg    = (cnt != 4'd0) & (cur != held);
  assign cnt_en = req & ~bad & ~chg & (cnt != WL);
  assign fin    = req & ~bad & ~chg & (cnt == WL);
  assign stall  = req & ~bad & (chg | (cnt != WL));
  assign err    = req & bad;
  assign we     = fin & wr;

  assign lane = (BIG_ENDIAN != 0) ? ~addr[1:0] : addr[1:0];
  assign hsel = lane[1];

  always_comb begin
    wd = wdata;
    be = 4'hF;
    unique case (size)
      2'b00: begin
        wd = {4{wdata[7:0]}};
        be = 4'b0001 << lane;
      end
      2'b01: begin
        wd = {2{wdata[15:0]}};
        be = hsel ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign word = mem[idx];
  assign b    = word[{lane, 3'b000} +: 8];
  assign h    = hsel ? word[31:16] : word[15:0];

  always_comb begin
    ext = word;
    unique case (1'b1)
      size == 2'b00: ext = uns ? {24'b0, b} : {{24{b[7]}}, b};
      size == 2'b01: ext = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default:       ext = word;
    endcase
  end

  assign rdata = (fin & rd & ~wr) ? ext : 32'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= 4'd0;
      held <= '0;
    end else begin
      cnt <= cnt_en ? cnt + 4'd1 : 4'd0;
      if (cnt_en)
        held <= cur;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && be[i])
        mem[idx][8*i +: 8] <= wd[8*i +: 8];
  end

endmodule

// File: tb/tb_dm_sized.sv
// Bench for dm_sized: two instances (WAIT=0 big-endian, WAIT=3
// little-endian) checked against a byte-array reference model.
module tb_dm_sized;

  localparam int DEPTH = 128;
  localparam int AW    = 10;
  localparam int NB    = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  addr  [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [1:0]  size  [2];
  logic        uns   [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        stall [2];
  logic        err   [2];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] lastrd;
  logic [7:0]  mb [2][NB];
  int          wt [2] = '{0, 3};
  bit          bend [2] = '{1'b1, 1'b0};

  always #5 clk = ~clk;

  dm_sized #(.DEPTH(DEPTH), .AW(AW), .WAIT(0), .BIG_ENDIAN(1)) u0 (
    .clk(clk), .rst(rst), .addr(addr[0]), .rd(rd[0]), .wr(wr[0]),
    .size(size[0]), .uns(uns[0]), .wdata(wdata[0]),
    .rdata(rdata[0]), .stall(stall[0]), .err(err[0])
  );

  dm_sized #(.DEPTH(DEPTH), .AW(AW), .WAIT(3), .BIG_ENDIAN(0)) u3 (
    .clk(clk), .rst(rst), .addr(addr[1]), .rd(rd[1]), .wr(wr[1]),
    .size(size[1]), .uns(uns[1]), .wdata(wdata[1]),
    .rdata(rdata[1]), .stall(stall[1]), .err(err[1])
  );

  task automatic chk(string tag, logic [31:0] o, logic [31:0] x);
    checks++;
    assert (o === x) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, x);
    end
  endtask

  function automatic int nbytes(int sz);
    return (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
  endfunction

  function automatic bit merr(int a, int sz);
    return (sz == 3) || (sz == 1 && a % 2 != 0) ||
           (sz == 2 && a % 4 != 0) || (a >= NB);
  endfunction

  function automatic logic [31:0] mload(int d, int a, int sz, bit u);
    int          n;
    logic [31:0] v;
    n = nbytes(sz);
    v = 32'b0;
    for (int i = 0; i < n; i++)
      if (bend[d]) v = (v << 8) | 32'(mb[d][a+i]);
      else         v = v | (32'(mb[d][a+i]) << (8*i));
    if (!u && n == 1 && v[7])  v = v | 32'hFFFFFF00;
    if (!u && n == 2 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  task automatic mstore(int d, int a, int sz, logic [31:0] v);
    int n;
    n = nbytes(sz);
    for (int i = 0; i < n; i++)
      if (bend[d]) mb[d][a+i] = 8'(v >> (8*(n-1-i)));
      else         mb[d][a+i] = 8'(v >> (8*i));
  endtask

  task automatic acc(int d, bit r, bit w, int sz, bit u, int a,
                     logic [31:0] v, string tag);
    bit          e;
    bit          ld;
    logic [31:0] ldv;
    e   = merr(a, sz);
    ld  = r && !w;
    ldv = (ld && !e) ? mload(d, a, sz, u) : 32'b0;
    @(negedge clk);
    rd[d]    = r;
    wr[d]    = w;
    size[d]  = sz[1:0];
    uns[d]   = u;
    addr[d]  = a[9:0];
    wdata[d] = v;
    if (e) begin
      #1;
      chk({tag, ".err"},   32'(err[d]),   32'd1);
      chk({tag, ".stall"}, 32'(stall[d]), 32'd0);
      chk({tag, ".rdata"}, rdata[d],      32'd0);
      lastrd = rdata[d];
    end else begin
      for (int k = 0; k <= wt[d]; k++) begin
        #1;
        chk({tag, ".stall"}, 32'(stall[d]), 32'(k < wt[d]));
        chk({tag, ".err"},   32'(err[d]),   32'd0);
        chk({tag, ".rdata"}, rdata[d],
            (k == wt[d] && ld) ? ldv : 32'b0);
        if (k == wt[d]) lastrd = rdata[d];
        else @(negedge clk);
      end
    end
    @(posedge clk);
    #1;
    rd[d] = 1'b0;
    wr[d] = 1'b0;
    if (!e && w) mstore(d, a, sz, v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, op, sz, a;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b1; wr[i] = 1'b0; size[i] = 2'b10; uns[i] = 1'b0;
      addr[i] = 10'h0; wdata[i] = 32'h0;
    end
    #2;
    for (int i = 0; i < 2; i++) begin
      chk("rst.stall", 32'(stall[i]), 32'd0);
      chk("rst.err",   32'(err[i]),   32'd0);
      chk("rst.rdata", rdata[i],      32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rd[0] = 1'b0;
    rd[1] = 1'b0;

    for (int i = 0; i < 2; i++)
      for (int j = 0; j < DEPTH; j++)
        acc(i, 1'b0, 1'b1, 2, 1'b0, j*4, $urandom, "fill");

    acc(0, 0, 1, 2, 0, 'h10, 32'h11223344, "sw10");
    acc(0, 1, 0, 0, 0, 'h11, 0, "lb11");
    chk("tp.lb11", lastrd, 32'h00000022);
    acc(0, 0, 1, 0, 0, 'h13, 32'h00000080, "sb13");
    acc(0, 1, 0, 0, 0, 'h13, 0, "lb13");
    chk("tp.lb13", lastrd, 32'hFFFFFF80);
    acc(0, 1, 0, 0, 1, 'h13, 0, "lbu13");
    chk("tp.lbu13", lastrd, 32'h00000080);
    acc(0, 1, 0, 2, 0, 'h10, 0, "lw10");
    chk("tp.lw10", lastrd, 32'h11223380);
    acc(0, 0, 1, 2, 0, 'h20, 32'h0, "sw20");
    acc(0, 0, 1, 1, 0, 'h22, 32'h0000BEEF, "sh22");
    acc(0, 1, 0, 2, 0, 'h20, 0, "lw20");
    chk("tp.lw20", lastrd, 32'h0000BEEF);
    acc(0, 1, 0, 1, 0, 'h22, 0, "lh22");
    chk("tp.lh22", lastrd, 32'hFFFFBEEF);
    acc(0, 1, 0, 1, 1, 'h22, 0, "lhu22");
    chk("tp.lhu22", lastrd, 32'h0000BEEF);
    acc(0, 1, 0, 2, 0, 'h02, 0, "lw02");
    acc(0, 0, 1, 2, 0, 'h04, 32'hCAFEF00D, "sw04");
    acc(0, 0, 1, 1, 0, 'h05, 32'h00001234, "sh05");
    acc(0, 1, 0, 2, 0, 'h04, 0, "lw04");
    chk("tp.lw04", lastrd, 32'hCAFEF00D);
    acc(0, 1, 0, 2, 0, NB, 0, "lwoor");
    acc(0, 1, 0, 3, 0, 'h08, 0, "rsvd");

    acc(1, 0, 1, 2, 0, 'h40, 32'h12345678, "w3sw40");
    acc(1, 1, 0, 2, 0, 'h40, 0, "w3lw40");
    chk("tp.w3lw40", lastrd, 32'h12345678);
    acc(1, 0, 1, 2, 0, 'h40, 32'h0, "w3clr");

    @(negedge clk);
    rd[1] = 1'b0; wr[1] = 1'b1; size[1] = 2'b10;
    addr[1] = 10'h40; wdata[1] = 32'hDEADBEEF;
    #1 chk("rstmid.stall1", 32'(stall[1]), 32'd1);
    @(negedge clk);
    #1 chk("rstmid.stall2", 32'(stall[1]), 32'd1);
    rst = 1'b1;
    #1 chk("rstmid.drop", 32'(stall[1]), 32'd0);
    chk("rstmid.err", 32'(err[1]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wr[1] = 1'b0;
    acc(1, 1, 0, 2, 0, 'h40, 0, "rstmid.lw");
    chk("tp.rstmid", lastrd, 32'h0);

    for (int it = 0; it < 300; it++) begin
      d  = $urandom_range(0, 1);
      op = $urandom_range(1, 3);
      sz = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      if ($urandom_range(0, 9) == 0)
        a = $urandom_range(0, 1023);
      else
        a = $urandom_range(0, NB-1) & ~(nbytes(sz) - 1);
      acc(d, op[0], op[1], sz, 1'($urandom), a, $urandom, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
